// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// gray_pkg
//   Shared FSM encodings, sweep counter width and saturating-increment helper
//   for the Gray-code sweep controller.
//   Revision: 1.0
// ============================================================================
package gray_pkg;

  localparam int c_STATE_W = 2;

  localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
  localparam logic [c_STATE_W-1:0] c_ST_RUN  = 2'd1;
  localparam logic [c_STATE_W-1:0] c_ST_DONE = 2'd2;

  localparam int c_SWEEP_CNT_W = 8;

  function automatic logic [c_SWEEP_CNT_W-1:0] sat_inc(input logic [c_SWEEP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/binary_to_gray.sv
`default_nettype none
// ============================================================================
// binary_to_gray
//   Purely combinational binary to reflected-Gray conversion.
//   Revision: 1.0
// ============================================================================
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule
`default_nettype wire

// File: rtl/gray_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// gray_sweep_ctrl
//   Sweeps a registered binary value from first to last (up or down, modulo
//   2^WIDTH) under valid/ready flow control, presenting its Gray code.
//   Revision: 1.0
// ============================================================================
module gray_sweep_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     dir,
  input  logic                     cont,
  input  logic [WIDTH-1:0]         first,
  input  logic [WIDTH-1:0]         last,
  input  logic                     abort,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         b_out,
  output logic [WIDTH-1:0]         g_out,
  output logic                     busy,
  output logic                     done,
  output logic [c_SWEEP_CNT_W-1:0] sweep_cnt
);

  logic [c_STATE_W-1:0]     r_state;
  logic [WIDTH-1:0]         r_b;
  logic [WIDTH-1:0]         r_first;
  logic [WIDTH-1:0]         r_last;
  logic                     r_dir;
  logic                     r_cont;
  logic [c_SWEEP_CNT_W-1:0] r_cnt;

  logic                     w_xfer;
  logic [WIDTH-1:0]         w_b_next;

  assign w_xfer   = out_valid & out_ready;
  // Natural WIDTH-bit overflow gives the modulo-2^WIDTH wrap in both directions.
  assign w_b_next = r_dir ? (r_b - 1'b1) : (r_b + 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_b     <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_dir   <= 1'b0;
      r_cont  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_first <= first;
            r_last  <= last;
            r_dir   <= dir;
            r_cont  <= cont;
            r_b     <= first;
            r_cnt   <= '0;
            r_state <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          // Abort wins over a coincident transfer: no step, no count update.
          if (abort) begin
            r_state <= c_ST_IDLE;
          end else if (w_xfer) begin
            if (r_b == r_last) begin
              r_cnt <= sat_inc(r_cnt);
              if (r_cont) begin
                r_b <= r_first;
              end else begin
                r_state <= c_ST_DONE;
              end
            end else begin
              r_b <= w_b_next;
            end
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  binary_to_gray #(
    .WIDTH(WIDTH)
  ) u_b2g (
    .bin  (r_b),
    .gray (g_out)
  );

  assign out_valid = (r_state == c_ST_RUN);
  assign done      = (r_state == c_ST_DONE);
  assign busy      = (r_state != c_ST_IDLE);
  assign b_out     = r_b;
  assign sweep_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gray_sweep_ctrl
//   Scoreboard bench: expected codes are queued when a sweep is launched and
//   popped on every accepted transfer.
//   Revision: 1.0
// ============================================================================
module tb_gray_sweep_ctrl;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic             cont = 1'b0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] first = '0;
  logic [WIDTH-1:0] last = '0;
  logic             out_valid;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] g_out;
  logic             busy;
  logic             done;
  logic [7:0]       sweep_cnt;

  int   n_checks = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   d0;
  exp_t q[$];

  always #5 clk = ~clk;

  gray_sweep_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .cont      (cont),
    .first     (first),
    .last      (last),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .b_out     (b_out),
    .g_out     (g_out),
    .busy      (busy),
    .done      (done),
    .sweep_cnt (sweep_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] g);
    exp_t e;
    e.b = b;
    e.g = g;
    q.push_back(e);
  endtask

  task automatic launch(input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] l,
                        input logic d, input logic c);
    first = f;
    last  = l;
    dir   = d;
    cont  = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && q.size() != 0; i++) step();
    check(tag, q.size(), 0);
  endtask

  task automatic finish_single(input string tag, input int exp_cnt);
    drain({tag, "_drain"});
    step();
    step();
    check({tag, "_done_pulses"}, done_seen - d0, 1);
    check({tag, "_sweep_cnt"}, sweep_cnt, exp_cnt);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
  endtask

  // Transfer monitor / scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (done) done_seen++;
    if (out_valid && out_ready) begin
      check("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sb_b_out", b_out, e.b);
        check("sb_g_out", g_out, e.g);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_b_out", b_out, 0);
    check("rst_g_out", g_out, 0);
    check("rst_cnt", sweep_cnt, 0);
    rst_n = 1'b1;
    step();

    // Abort in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);

    // Single sweep up 3..6
    d0 = done_seen;
    push(4'd3, 4'b0010); push(4'd4, 4'b0110); push(4'd5, 4'b0111); push(4'd6, 4'b0101);
    launch(4'd3, 4'd6, 1'b0, 1'b0);
    finish_single("up", 1);

    // Wrap up 14..1
    d0 = done_seen;
    push(4'd14, 4'b1001); push(4'd15, 4'b1000); push(4'd0, 4'b0000); push(4'd1, 4'b0001);
    launch(4'd14, 4'd1, 1'b0, 1'b0);
    finish_single("wrap_up", 1);

    // Down with wrap 2..13
    d0 = done_seen;
    push(4'd2, 4'b0011); push(4'd1, 4'b0001); push(4'd0, 4'b0000);
    push(4'd15, 4'b1000); push(4'd14, 4'b1001); push(4'd13, 4'b1011);
    launch(4'd2, 4'd13, 1'b1, 1'b0);
    finish_single("down", 1);

    // Backpressure: stall 3 cycles at b_out=5
    d0 = done_seen;
    push(4'd3, 4'b0010); push(4'd4, 4'b0110); push(4'd5, 4'b0111); push(4'd6, 4'b0101);
    launch(4'd3, 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 20 && b_out != 4'd5; i++) step();
    out_ready = 1'b0;
    check("bp_reach5", b_out, 5);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_g", g_out, 4'b0111);
      check("bp_hold_b", b_out, 5);
      check("bp_hold_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    finish_single("bp", 1);

    // Continuous 0..1, abort coincident with 5th transfer
    d0 = done_seen;
    push(4'd0, 4'b0000); push(4'd1, 4'b0001); push(4'd0, 4'b0000);
    push(4'd1, 4'b0001); push(4'd0, 4'b0000);
    launch(4'd0, 4'd1, 1'b0, 1'b1);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("cont_abort_valid", out_valid, 0);
    check("cont_abort_busy", busy, 0);
    check("cont_abort_done", done, 0);
    check("cont_abort_cnt", sweep_cnt, 2);
    check("cont_abort_left", q.size(), 0);
    step();
    check("cont_abort_no_done", done_seen - d0, 0);

    // Abort coincident with a final-code transfer suppresses the count
    push(4'd0, 4'b0000); push(4'd1, 4'b0001);
    launch(4'd0, 4'd1, 1'b0, 1'b1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_last_cnt", sweep_cnt, 0);
    check("abort_last_busy", busy, 0);
    check("abort_last_left", q.size(), 0);

    // Reset mid-sweep at b_out=4
    d0 = done_seen;
    push(4'd0, 4'b0000); push(4'd1, 4'b0001); push(4'd2, 4'b0011);
    push(4'd3, 4'b0010); push(4'd4, 4'b0110);
    launch(4'd0, 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 20 && b_out != 4'd4; i++) step();
    check("mid_rst_reach4", b_out, 4);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_b_out", b_out, 0);
    check("mid_rst_g_out", g_out, 0);
    check("mid_rst_cnt", sweep_cnt, 0);
    check("mid_rst_left", q.size(), 0);
    rst_n = 1'b1;
    step();
    check("mid_rst_no_done", done_seen - d0, 0);

    // Single-code sweep after reset
    d0 = done_seen;
    push(4'd3, 4'b0010);
    launch(4'd3, 4'd3, 1'b0, 1'b0);
    finish_single("one_code", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_sweep_ctrl.md
GRAY_SWEEP_CTRL -- requirements
Module: gray_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the code width of the sequenced binary_to_gray datapath.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  begin a sweep; sampled only in IDLE.
REQ-005 SHALL have port dir  input  1  step direction, 0 = +1, 1 = -1 (mod 2^WIDTH); latched at start.
REQ-006 SHALL have port cont  input  1  0 = single sweep, 1 = repeat sweeps until abort; latched at start.
REQ-007 SHALL have port first  input  WIDTH  first binary value of the sweep; latched at start.
REQ-008 SHALL have port last  input  WIDTH  last binary value of the sweep, inclusive; latched at start.
REQ-009 SHALL have port abort  input  1  terminate the sweep immediately.
REQ-010 SHALL have port out_ready  input  1  sink accepts the current code.
REQ-011 SHALL have port out_valid  output  1  b_out/g_out hold a valid code.
REQ-012 SHALL have port b_out  output  WIDTH  registered binary value.
REQ-013 SHALL have port g_out  output  WIDTH  Gray code of b_out (b XOR b>>1).
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final code of a single sweep is accepted.
REQ-016 SHALL have port sweep_cnt  output  8  number of completed sweeps since start, saturating at 255.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL, in IDLE with start=1, latch first/last/dir/cont, load b_out=first, clear sweep_cnt, and enter RUN on the next edge, with out_valid=1 in the first RUN cycle (1-cycle latency).
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL count a transfer only in a cycle where out_valid=1 and out_ready=1.
REQ-021 SHALL hold b_out, g_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on a transfer with b_out!=last, step b_out by +1 or -1 modulo 2^WIDTH, wrapping 2^WIDTH-1 <-> 0.
REQ-023 SHALL, on a transfer with b_out=last, increment sweep_cnt (saturating), and if cont=0 enter DONE with out_valid=0, else reload b_out=first and stay in RUN.
REQ-024 SHALL emit exactly (last-first) mod 2^WIDTH + 1 codes per sweep for dir=0, and (first-last) mod 2^WIDTH + 1 codes for dir=1; first=last emits one code.
REQ-025 SHALL assert done for exactly the one DONE cycle, then return to IDLE with busy=0.
REQ-026 SHALL, when abort=1 in RUN or DONE, enter IDLE on the next edge with out_valid=0 and done=0; abort has priority over a simultaneous transfer, whose code the sink has still consumed, and over the sweep_cnt increment of that transfer.
REQ-027 SHALL ignore abort in IDLE.
REQ-028 SHALL derive g_out combinationally from registered b_out, with no added latency.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, enter IDLE and drive out_valid=0, busy=0, done=0, b_out=0, g_out=0, sweep_cnt=0.
REQ-030 SHALL give reset priority over start and abort, including mid-sweep; no done pulse results.

Structure
REQ-031 SHALL take FSM state encodings and the sweep_cnt width (8) from shared package gray_pkg.
REQ-032 SHALL instantiate the existing binary_to_gray module as its only sub-module, producing g_out from b_out.

Verification
REQ-033 SHALL cover single sweep up: first=3, last=6, dir=0, cont=0, out_ready=1 -> g_out 0010,0110,0111,0101; done pulses once; sweep_cnt=1.
REQ-034 SHALL cover wrap up: first=14, last=1, dir=0 -> b_out 14,15,0,1; g_out 1001,1000,0000,0001.
REQ-035 SHALL cover down with wrap: first=2, last=13, dir=1 -> b_out 2,1,0,15,14,13; g_out 0011,0001,0000,1000,1001,1011.
REQ-036 SHALL cover backpressure: out_ready low 3 cycles at b_out=5 -> g_out holds 0111, no code skipped or repeated.
REQ-037 SHALL cover continuous mode plus abort: first=0, last=1, cont=1, abort after 5 transfers -> codes 0000,0001,0000,0001,0000; sweep_cnt=2; IDLE next edge; no done.
REQ-038 SHALL cover reset mid-sweep: rst_n=0 while b_out=4 -> next edge all outputs 0, busy=0; a following start works normally.
